// File: rtl/cu_pkg.sv
// Shared types for the vector issue control unit: control word, opcodes, FSM states.
package cu_pkg;

    typedef struct packed {
        logic       PCSrc;
        logic       RegWrite;
        logic       RegWriteV;
        logic       MemtoReg;
        logic       MemWrite;
        logic       MemSrc;
        logic       Branch;
        logic       ALUSrc;
        logic [2:0] ALUControl;
        logic [1:0] ImmSrc;
    } cu_ctrl_t;

    localparam logic [5:0] OP_RALU = 6'b000000;
    localparam logic [5:0] OP_VALU = 6'b100000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LD   = 6'b011001;
    localparam logic [5:0] OP_ST   = 6'b011000;
    localparam logic [5:0] OP_VLD  = 6'b111001;
    localparam logic [5:0] OP_VST  = 6'b111000;
    localparam logic [5:0] OP_BEQ  = 6'b001100;
    localparam logic [5:0] OP_BGT  = 6'b001101;
    localparam logic [5:0] OP_JUMP = 6'b000100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCALAR = 2'd1,
        VECTOR = 2'd2
    } cu_state_e;

endpackage

// File: rtl/cu_decoder.sv
// Combinational opcode/function decode into the control word, illegal flag and vector class.
module cu_decoder
    import cu_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [2:0] func_i,
    output cu_ctrl_t   ctrl_o,
    output logic       illegal_o,
    output logic       is_vector_o
);

    always_comb begin
        ctrl_o    = '0;
        illegal_o = 1'b0;
        case (opcode_i)
            OP_RALU: begin
                ctrl_o.RegWrite   = 1'b1;
                ctrl_o.ALUControl = func_i;
            end
            OP_VALU: begin
                ctrl_o.RegWriteV  = 1'b1;
                ctrl_o.ALUControl = func_i;
            end
            OP_ADDI: begin
                ctrl_o.RegWrite = 1'b1;
                ctrl_o.ALUSrc   = 1'b1;
            end
            OP_LD: begin
                ctrl_o.RegWrite = 1'b1;
                ctrl_o.MemtoReg = 1'b1;
                ctrl_o.ALUSrc   = 1'b1;
            end
            OP_ST: begin
                ctrl_o.MemWrite = 1'b1;
                ctrl_o.ALUSrc   = 1'b1;
            end
            OP_VLD: begin
                ctrl_o.RegWriteV = 1'b1;
                ctrl_o.MemtoReg  = 1'b1;
                ctrl_o.ALUSrc    = 1'b1;
            end
            OP_VST: begin
                ctrl_o.MemWrite = 1'b1;
                ctrl_o.MemSrc   = 1'b1;
                ctrl_o.ALUSrc   = 1'b1;
            end
            OP_BEQ, OP_BGT: begin
                ctrl_o.Branch     = 1'b1;
                ctrl_o.ALUControl = 3'b001;
            end
            OP_JUMP: begin
                ctrl_o.Branch = 1'b1;
                ctrl_o.PCSrc  = 1'b1;
            end
            default: illegal_o = 1'b1;
        endcase
    end

    // Illegal opcodes always issue as a single scalar beat.
    assign is_vector_o = opcode_i[5] && !illegal_o;

endmodule

// File: rtl/vec_issue_control_unit.sv
// Multi-beat issue stage: registers the decoded control word and emits vector beats with lane masks.
// Optional CU_PERF_COUNTERS_EN adds saturating InstrCount/StallCount outputs.
module vec_issue_control_unit
    import cu_pkg::*;
#(
    parameter int unsigned NUM_LANES      = 16,
    parameter int unsigned LANES_PER_BEAT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic [5:0]           Opcode,
    input  logic [2:0]           Func,
    input  logic [4:0]           Rd,
    input  logic                 Flush,
    input  logic                 OutReady,
    output logic                 OutValid,
    output cu_ctrl_t             Ctrl,
    output logic [4:0]           RdOut,
    output logic [NUM_LANES-1:0] LaneMask,
    output logic [((NUM_LANES/LANES_PER_BEAT) > 1 ? $clog2(NUM_LANES/LANES_PER_BEAT) : 1)-1:0] BeatIdx,
    output logic                 LastBeat,
    output logic                 Illegal,
    output logic                 Busy
`ifdef CU_PERF_COUNTERS_EN
    ,
    output logic [31:0]          InstrCount,
    output logic [31:0]          StallCount
`endif
);

    localparam int unsigned BEATS = NUM_LANES / LANES_PER_BEAT;
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    cu_state_e            state_q;
    cu_ctrl_t             ctrl_q;
    logic [4:0]           rd_q;
    logic [NUM_LANES-1:0] mask_q;
    logic [BW-1:0]        beat_q;
    logic [BW-1:0]        beat_d;
    logic                 last_q;
    logic                 illegal_q;
    logic                 valid_q;
    logic                 busy_q;

    cu_ctrl_t dec_ctrl;
    logic     dec_illegal;
    logic     dec_is_vector;
    logic     accept;
    logic     fire;

    cu_decoder u_decoder (
        .opcode_i    (Opcode),
        .func_i      (Func),
        .ctrl_o      (dec_ctrl),
        .illegal_o   (dec_illegal),
        .is_vector_o (dec_is_vector)
    );

    function automatic logic [NUM_LANES-1:0] beat_mask(input logic [BW-1:0] b);
        logic [NUM_LANES-1:0] base;
        base                     = '0;
        base[LANES_PER_BEAT-1:0] = '1;
        return base << (32'(b) * LANES_PER_BEAT);
    endfunction

    assign fire    = valid_q && OutReady;
    assign InReady = !Flush && ((state_q == IDLE) || (fire && last_q));
    assign accept  = InValid && InReady;
    assign beat_d  = beat_q + BW'(1);

    // Flush outranks every handshake; accept also covers the no-bubble reload on the last beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ctrl_q    <= '0;
            rd_q      <= '0;
            mask_q    <= '0;
            beat_q    <= '0;
            last_q    <= 1'b0;
            illegal_q <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else if (Flush || (fire && last_q && !accept)) begin
            state_q   <= IDLE;
            ctrl_q    <= '0;
            rd_q      <= '0;
            mask_q    <= '0;
            beat_q    <= '0;
            last_q    <= 1'b0;
            illegal_q <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else if (accept) begin
            state_q   <= dec_is_vector ? VECTOR : SCALAR;
            ctrl_q    <= dec_ctrl;
            rd_q      <= Rd;
            mask_q    <= dec_is_vector ? beat_mask('0) : '0;
            beat_q    <= '0;
            last_q    <= dec_is_vector ? (BEATS == 1) : 1'b1;
            illegal_q <= dec_illegal;
            valid_q   <= 1'b1;
            busy_q    <= 1'b1;
        end else if (fire && state_q == VECTOR) begin
            beat_q <= beat_d;
            mask_q <= beat_mask(beat_d);
            last_q <= (beat_d == BW'(BEATS - 1));
        end
    end

    assign OutValid = valid_q;
    assign Ctrl     = ctrl_q;
    assign RdOut    = rd_q;
    assign LaneMask = mask_q;
    assign BeatIdx  = beat_q;
    assign LastBeat = last_q;
    assign Illegal  = illegal_q;
    assign Busy     = busy_q;

`ifdef CU_PERF_COUNTERS_EN
    logic [31:0] instr_cnt_q;
    logic [31:0] stall_cnt_q;

    // Saturating counters, deliberately blind to Flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (accept && instr_cnt_q != '1)
                instr_cnt_q <= instr_cnt_q + 32'd1;
            if (valid_q && !OutReady && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign InstrCount = instr_cnt_q;
    assign StallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_vec_issue_control_unit.sv
// Directed bench for vec_issue_control_unit with hand-computed expectations per scenario.
module tb_vec_issue_control_unit;
    import cu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        InValid;
    logic        InReady;
    logic [5:0]  Opcode;
    logic [2:0]  Func;
    logic [4:0]  Rd;
    logic        Flush;
    logic        OutReady;
    logic        OutValid;
    cu_ctrl_t    Ctrl;
    logic [4:0]  RdOut;
    logic [15:0] LaneMask;
    logic [1:0]  BeatIdx;
    logic        LastBeat;
    logic        Illegal;
    logic        Busy;
`ifdef CU_PERF_COUNTERS_EN
    logic [31:0] InstrCount;
    logic [31:0] StallCount;
`endif

    int checks   = 0;
    int failures = 0;

    vec_issue_control_unit #(.NUM_LANES(16), .LANES_PER_BEAT(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .InValid  (InValid),
        .InReady  (InReady),
        .Opcode   (Opcode),
        .Func     (Func),
        .Rd       (Rd),
        .Flush    (Flush),
        .OutReady (OutReady),
        .OutValid (OutValid),
        .Ctrl     (Ctrl),
        .RdOut    (RdOut),
        .LaneMask (LaneMask),
        .BeatIdx  (BeatIdx),
        .LastBeat (LastBeat),
        .Illegal  (Illegal),
        .Busy     (Busy)
`ifdef CU_PERF_COUNTERS_EN
        ,
        .InstrCount (InstrCount),
        .StallCount (StallCount)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; InValid = 1'b0; Opcode = '0; Func = '0; Rd = '0;
        Flush = 1'b0; OutReady = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        checks++;
        if ({OutValid, Ctrl, RdOut, LaneMask, BeatIdx, LastBeat, Illegal, Busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: ov=%b ctrl=%h rd=%h mask=%h beat=%0d last=%b ill=%b busy=%b",
                     OutValid, Ctrl, RdOut, LaneMask, BeatIdx, LastBeat, Illegal, Busy);
        end
        checks++;
        if (InReady !== 1'b1) begin
            failures++;
            $display("FAIL reset_inready: got %b want 1", InReady);
        end
    endtask

    task automatic test_scalar_back_to_back();
        cu_ctrl_t exp;
        exp = '0; exp.RegWrite = 1'b1;
        InValid = 1'b1; Opcode = 6'b000000; Func = 3'b000; Rd = 5'd3; OutReady = 1'b1;
        step();
        Rd = 5'd7;
        checks++;
        if (OutValid !== 1'b1 || Ctrl !== exp || RdOut !== 5'd3 || LaneMask !== 16'h0000 || LastBeat !== 1'b1) begin
            failures++;
            $display("FAIL scalar_first: ov=%b ctrl=%h rd=%0d mask=%h last=%b want ov=1 ctrl=%h rd=3 mask=0000 last=1",
                     OutValid, Ctrl, RdOut, LaneMask, LastBeat, exp);
        end
        checks++;
        if (InReady !== 1'b1) begin
            failures++;
            $display("FAIL scalar_inready_reload: got %b want 1", InReady);
        end
        step();
        InValid = 1'b0;
        checks++;
        if (OutValid !== 1'b1 || RdOut !== 5'd7 || Ctrl !== exp) begin
            failures++;
            $display("FAIL scalar_second_no_bubble: ov=%b rd=%0d ctrl=%h want ov=1 rd=7 ctrl=%h", OutValid, RdOut, Ctrl, exp);
        end
        step();
        checks++;
        if (OutValid !== 1'b0 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL scalar_drain: ov=%b busy=%b want 0 0", OutValid, Busy);
        end
    endtask

    task automatic test_vector_alu();
        logic [15:0] masks [4];
        cu_ctrl_t exp;
        masks[0] = 16'h000F; masks[1] = 16'h00F0; masks[2] = 16'h0F00; masks[3] = 16'hF000;
        exp = '0; exp.RegWriteV = 1'b1; exp.ALUControl = 3'b001;
        InValid = 1'b1; Opcode = 6'b100000; Func = 3'b001; Rd = 5'd9; OutReady = 1'b1;
        step();
        InValid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (OutValid !== 1'b1 || LaneMask !== masks[b] || Ctrl !== exp || BeatIdx !== 2'(b)
                || LastBeat !== (b == 3) || RdOut !== 5'd9) begin
                failures++;
                $display("FAIL vector_beat%0d: ov=%b mask=%h ctrl=%h beat=%0d last=%b rd=%0d want mask=%h ctrl=%h",
                         b, OutValid, LaneMask, Ctrl, BeatIdx, LastBeat, RdOut, masks[b], exp);
            end
            checks++;
            if (InReady !== (b == 3)) begin
                failures++;
                $display("FAIL vector_inready_beat%0d: got %b want %b", b, InReady, (b == 3));
            end
            step();
        end
        checks++;
        if (OutValid !== 1'b0 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL vector_drain: ov=%b busy=%b want 0 0", OutValid, Busy);
        end
    endtask

    task automatic test_stall();
        cu_ctrl_t exp;
        exp = '0; exp.MemWrite = 1'b1; exp.MemSrc = 1'b1; exp.ALUSrc = 1'b1;
        InValid = 1'b1; Opcode = 6'b111000; Func = 3'b000; Rd = 5'd2; OutReady = 1'b1;
        step();
        InValid = 1'b0;
`ifdef CU_PERF_COUNTERS_EN
        checks++;
        if (InstrCount !== 32'd4) begin
            failures++;
            $display("FAIL instr_count: got %0d want 4", InstrCount);
        end
`endif
        step();
        OutReady = 1'b0;
        for (int s = 0; s < 3; s++) begin
            step();
            checks++;
            if (OutValid !== 1'b1 || Ctrl !== exp || LaneMask !== 16'h00F0 || BeatIdx !== 2'd1 || LastBeat !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold%0d: ov=%b ctrl=%h mask=%h beat=%0d last=%b want ctrl=%h mask=00F0 beat=1",
                         s, OutValid, Ctrl, LaneMask, BeatIdx, LastBeat, exp);
            end
        end
`ifdef CU_PERF_COUNTERS_EN
        checks++;
        if (StallCount !== 32'd3) begin
            failures++;
            $display("FAIL stall_count: got %0d want 3", StallCount);
        end
`endif
        OutReady = 1'b1;
        step();
        checks++;
        if (LaneMask !== 16'h0F00 || BeatIdx !== 2'd2) begin
            failures++;
            $display("FAIL stall_resume: mask=%h beat=%0d want 0F00 2", LaneMask, BeatIdx);
        end
        step(); step();
        checks++;
        if (OutValid !== 1'b0) begin
            failures++;
            $display("FAIL stall_drain: ov=%b want 0", OutValid);
        end
    endtask

    task automatic test_flush();
        InValid = 1'b1; Opcode = 6'b111001; Func = 3'b000; Rd = 5'd4; OutReady = 1'b1;
        step();
        InValid = 1'b0;
        step(); step();
        checks++;
        if (BeatIdx !== 2'd2 || OutValid !== 1'b1) begin
            failures++;
            $display("FAIL flush_setup: beat=%0d ov=%b want 2 1", BeatIdx, OutValid);
        end
        Flush = 1'b1; InValid = 1'b1; Opcode = 6'b000000;
        #1;
        checks++;
        if (InReady !== 1'b0) begin
            failures++;
            $display("FAIL flush_inready: got %b want 0", InReady);
        end
        step();
        Flush = 1'b0; InValid = 1'b0;
        checks++;
        if (OutValid !== 1'b0 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_kill: ov=%b busy=%b want 0 0", OutValid, Busy);
        end
        step();
        checks++;
        if (OutValid !== 1'b0) begin
            failures++;
            $display("FAIL flush_not_accepted: ov=%b want 0", OutValid);
        end
    endtask

    task automatic test_illegal();
        InValid = 1'b1; Opcode = 6'b111111; Func = 3'b101; Rd = 5'd1; OutReady = 1'b1;
        step();
        InValid = 1'b0;
        checks++;
        if (OutValid !== 1'b1 || Illegal !== 1'b1 || Ctrl !== '0 || LastBeat !== 1'b1 || LaneMask !== 16'h0000) begin
            failures++;
            $display("FAIL illegal_beat: ov=%b ill=%b ctrl=%h last=%b mask=%h want 1 1 0 1 0000",
                     OutValid, Illegal, Ctrl, LastBeat, LaneMask);
        end
        step();
        checks++;
        if (OutValid !== 1'b0) begin
            failures++;
            $display("FAIL illegal_single: ov=%b want 0", OutValid);
        end
    endtask

    task automatic test_reset_mid_vector();
        cu_ctrl_t exp;
        InValid = 1'b1; Opcode = 6'b100000; Func = 3'b010; Rd = 5'd6; OutReady = 1'b1;
        step();
        InValid = 1'b0;
        step();
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({OutValid, Ctrl, RdOut, LaneMask, BeatIdx, LastBeat, Illegal, Busy} !== '0) begin
            failures++;
            $display("FAIL reset_mid_vector: ov=%b ctrl=%h rd=%h mask=%h beat=%0d last=%b busy=%b",
                     OutValid, Ctrl, RdOut, LaneMask, BeatIdx, LastBeat, Busy);
        end
`ifdef CU_PERF_COUNTERS_EN
        checks++;
        if (InstrCount !== 32'd0 || StallCount !== 32'd0) begin
            failures++;
            $display("FAIL reset_counters: instr=%0d stall=%0d want 0 0", InstrCount, StallCount);
        end
`endif
        #1 rst = 1'b0;
        exp = '0; exp.Branch = 1'b1; exp.PCSrc = 1'b1;
        InValid = 1'b1; Opcode = 6'b000100; Func = 3'b000; Rd = 5'd0;
        step();
        InValid = 1'b0;
        checks++;
        if (OutValid !== 1'b1 || Ctrl !== exp) begin
            failures++;
            $display("FAIL jump_after_reset: ov=%b ctrl=%h want 1 %h", OutValid, Ctrl, exp);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_scalar_back_to_back();
        test_vector_alu();
        test_stall();
        test_flush();
        test_illegal();
        test_reset_mid_vector();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
